// File: rtl/if_id_skid_stage.sv
// IF/ID pipeline register with a one-entry skid buffer so in_ready is purely registered.
// Holds up to two fetched entries in order and counts cycles where ID back-pressures a valid entry.
module if_id_skid_stage #(
   parameter int                     PC_WIDTH    = 32,
   parameter int                     INSTR_WIDTH = 32,
   parameter logic [INSTR_WIDTH-1:0] NOP_INSTR   = '0,
   parameter int                     CNT_WIDTH   = 16
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic                   flush,
   input  logic                   in_valid,
   output logic                   in_ready,
   input  logic [PC_WIDTH-1:0]    pc_incr_in,
   input  logic [INSTR_WIDTH-1:0] instr_in,
   output logic                   out_valid,
   input  logic                   out_ready,
   output logic [PC_WIDTH-1:0]    pc_incr_out,
   output logic [INSTR_WIDTH-1:0] instr_out,
   output logic [CNT_WIDTH-1:0]   stall_cnt
);

   localparam logic [1:0] S_EMPTY = 2'd0;
   localparam logic [1:0] S_ONE   = 2'd1;
   localparam logic [1:0] S_FULL  = 2'd2;

   localparam logic [CNT_WIDTH-1:0] CNT_MAX = {CNT_WIDTH{1'b1}};

   logic [1:0]             r_state;
   logic [PC_WIDTH-1:0]    r_main_pc;
   logic [INSTR_WIDTH-1:0] r_main_instr;
   logic [PC_WIDTH-1:0]    r_skid_pc;
   logic [INSTR_WIDTH-1:0] r_skid_instr;
   logic [CNT_WIDTH-1:0]   r_stall_cnt;

   logic w_in_ready;
   logic w_out_valid;
   logic w_push;
   logic w_pop;

   // in_ready depends only on registered state and reset, never on out_ready
   always_comb begin
      w_in_ready  = (r_state != S_FULL) && !reset;
      w_out_valid = (r_state == S_ONE) || (r_state == S_FULL);
      w_push      = in_valid && w_in_ready && !flush;
      w_pop       = w_out_valid && out_ready;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         r_state      <= S_EMPTY;
         r_main_pc    <= '0;
         r_main_instr <= NOP_INSTR;
         r_skid_pc    <= '0;
         r_skid_instr <= NOP_INSTR;
         r_stall_cnt  <= '0;
      end else begin
         if (w_out_valid && !out_ready && (r_stall_cnt != CNT_MAX))
            r_stall_cnt <= r_stall_cnt + CNT_WIDTH'(1);

         // Flush kills both entries; a concurrent pop is simply consumed by ID
         if (flush) begin
            r_state <= S_EMPTY;
         end else begin
            case (r_state)
               S_EMPTY: begin
                  if (w_push) begin
                     r_main_pc    <= pc_incr_in;
                     r_main_instr <= instr_in;
                     r_state      <= S_ONE;
                  end
               end
               S_ONE: begin
                  if (w_push && w_pop) begin
                     r_main_pc    <= pc_incr_in;
                     r_main_instr <= instr_in;
                  end else if (w_push) begin
                     r_skid_pc    <= pc_incr_in;
                     r_skid_instr <= instr_in;
                     r_state      <= S_FULL;
                  end else if (w_pop) begin
                     r_state <= S_EMPTY;
                  end
               end
               S_FULL: begin
                  if (w_pop) begin
                     r_main_pc    <= r_skid_pc;
                     r_main_instr <= r_skid_instr;
                     r_state      <= S_ONE;
                  end
               end
               default: r_state <= S_EMPTY;
            endcase
         end
      end
   end

   assign in_ready    = w_in_ready;
   assign out_valid   = w_out_valid;
   assign pc_incr_out = w_out_valid ? r_main_pc : '0;
   assign instr_out   = w_out_valid ? r_main_instr : NOP_INSTR;
   assign stall_cnt   = r_stall_cnt;

endmodule

// File: tb/tb_if_id_skid_stage.sv
// Bench for if_id_skid_stage: directed vector table, hand sequences and randomized queue-model run.
module tb_if_id_skid_stage;

   localparam int          PW  = 32;
   localparam int          IW  = 32;
   localparam int          CW  = 4;
   localparam logic [31:0] NOP = 32'h0000_0013;

   logic          clk;
   logic          reset;
   logic          flush;
   logic          in_valid;
   logic          in_ready;
   logic [PW-1:0] pc_incr_in;
   logic [IW-1:0] instr_in;
   logic          out_valid;
   logic          out_ready;
   logic [PW-1:0] pc_incr_out;
   logic [IW-1:0] instr_out;
   logic [CW-1:0] stall_cnt;

   int n_checks;
   int n_fail;

   if_id_skid_stage #(
      .PC_WIDTH(PW), .INSTR_WIDTH(IW), .NOP_INSTR(NOP), .CNT_WIDTH(CW)
   ) dut (
      .clk(clk), .reset(reset), .flush(flush),
      .in_valid(in_valid), .in_ready(in_ready),
      .pc_incr_in(pc_incr_in), .instr_in(instr_in),
      .out_valid(out_valid), .out_ready(out_ready),
      .pc_incr_out(pc_incr_out), .instr_out(instr_out),
      .stall_cnt(stall_cnt)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Reference model: ordered queue of {pc, instr}, capacity two, plus a saturating counter
   logic [63:0] m_q[$];
   int          m_cnt;

   typedef struct {
      logic        rst, fl, iv, ordy;
      logic [31:0] pc, ins;
      logic        e_ov, e_ir;
      logic [31:0] e_pc, e_ins;
      int          e_cnt;
   } vec_t;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic drive(input logic r, input logic fl, input logic iv,
                        input logic [31:0] pc, input logic [31:0] ins, input logic ordy);
      @(negedge clk);
      reset = r; flush = fl; in_valid = iv; pc_incr_in = pc; instr_in = ins; out_ready = ordy;
      #1;
   endtask

   // Advance one rising edge, updating the model from the inputs currently driven
   task automatic tick();
      logic ov, ir, push, pop;
      ov   = (m_q.size() > 0);
      ir   = (m_q.size() < 2) && !reset;
      push = in_valid && ir && !flush;
      pop  = ov && out_ready;
      if (reset) begin
         m_q.delete();
         m_cnt = 0;
      end else begin
         if (ov && !out_ready && m_cnt < (1 << CW) - 1) m_cnt++;
         if (flush) m_q.delete();
         else begin
            if (pop) m_q.delete(0);
            if (push) m_q.push_back({pc_incr_in, instr_in});
         end
      end
      @(posedge clk);
   endtask

   task automatic check_model(input string tag);
      logic        ov;
      logic [63:0] hd;
      ov = (m_q.size() > 0);
      hd = ov ? m_q[0] : {32'h0, NOP};
      check({tag, "_out_valid"}, 64'(out_valid), 64'(ov));
      check({tag, "_in_ready"},  64'(in_ready), 64'((m_q.size() < 2) && !reset));
      check({tag, "_pc"},        64'(pc_incr_out), 64'(hd[63:32]));
      check({tag, "_instr"},     64'(instr_out), 64'(hd[31:0]));
      check({tag, "_stall_cnt"}, 64'(stall_cnt), 64'(m_cnt));
   endtask

   task automatic check_vec(input string tag, input vec_t v);
      check({tag, "_out_valid"}, 64'(out_valid), 64'(v.e_ov));
      check({tag, "_in_ready"},  64'(in_ready), 64'(v.e_ir));
      check({tag, "_pc"},        64'(pc_incr_out), 64'(v.e_pc));
      check({tag, "_instr"},     64'(instr_out), 64'(v.e_ins));
      check({tag, "_stall_cnt"}, 64'(stall_cnt), 64'(v.e_cnt));
   endtask

   localparam logic [31:0] PA = 32'h4, IA = 32'h2008_0005;
   localparam logic [31:0] PB = 32'h8, IB = 32'h0000_0113;
   localparam logic [31:0] PC = 32'hC, IC = 32'h0000_0033;

   vec_t tbl[19];

   initial begin
      n_checks = 0; n_fail = 0; m_cnt = 0;
      reset = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
      pc_incr_in = '0; instr_in = '0;

      //                rst fl  iv  ordy  pc  ins   ov  ir  pc  ins  cnt
      tbl[0]  = '{1'b0,1'b0,1'b1,1'b1, PA, IA, 1'b0,1'b1,32'h0,NOP, 0};
      tbl[1]  = '{1'b0,1'b0,1'b1,1'b1, PB, IB, 1'b1,1'b1,PA,   IA,  0};
      tbl[2]  = '{1'b0,1'b0,1'b0,1'b1, 0,  0,  1'b1,1'b1,PB,   IB,  0};
      tbl[3]  = '{1'b0,1'b0,1'b0,1'b0, 0,  0,  1'b0,1'b1,32'h0,NOP, 0};
      tbl[4]  = '{1'b0,1'b0,1'b1,1'b0, PA, IA, 1'b0,1'b1,32'h0,NOP, 0};
      tbl[5]  = '{1'b0,1'b0,1'b1,1'b0, PB, IB, 1'b1,1'b1,PA,   IA,  0};
      tbl[6]  = '{1'b0,1'b0,1'b1,1'b0, PC, IC, 1'b1,1'b0,PA,   IA,  1};
      tbl[7]  = '{1'b0,1'b0,1'b0,1'b0, 0,  0,  1'b1,1'b0,PA,   IA,  2};
      tbl[8]  = '{1'b0,1'b0,1'b0,1'b0, 0,  0,  1'b1,1'b0,PA,   IA,  3};
      tbl[9]  = '{1'b0,1'b0,1'b0,1'b1, 0,  0,  1'b1,1'b0,PA,   IA,  4};
      tbl[10] = '{1'b0,1'b0,1'b0,1'b1, 0,  0,  1'b1,1'b1,PB,   IB,  4};
      tbl[11] = '{1'b0,1'b0,1'b0,1'b0, 0,  0,  1'b0,1'b1,32'h0,NOP, 4};
      tbl[12] = '{1'b0,1'b0,1'b1,1'b0, PA, IA, 1'b0,1'b1,32'h0,NOP, 4};
      tbl[13] = '{1'b0,1'b0,1'b1,1'b0, PB, IB, 1'b1,1'b1,PA,   IA,  4};
      tbl[14] = '{1'b0,1'b1,1'b1,1'b1, PC, IC, 1'b1,1'b0,PA,   IA,  5};
      tbl[15] = '{1'b0,1'b0,1'b0,1'b0, 0,  0,  1'b0,1'b1,32'h0,NOP, 5};
      tbl[16] = '{1'b0,1'b0,1'b0,1'b1, 0,  0,  1'b0,1'b1,32'h0,NOP, 5};
      tbl[17] = '{1'b0,1'b1,1'b1,1'b0, PC, IC, 1'b0,1'b1,32'h0,NOP, 5};
      tbl[18] = '{1'b0,1'b0,1'b0,1'b1, 0,  0,  1'b0,1'b1,32'h0,NOP, 5};

      // Two reset cycles; in_ready must be low while reset is asserted
      drive(1, 0, 1, PA, IA, 1); tick();
      drive(1, 0, 1, PA, IA, 1);
      check("rst_in_ready_low", 64'(in_ready), 64'(0));
      tick();

      for (int i = 0; i < 19; i++) begin
         drive(tbl[i].rst, tbl[i].fl, tbl[i].iv, tbl[i].pc, tbl[i].ins, tbl[i].ordy);
         check_vec($sformatf("vec%0d", i), tbl[i]);
         tick();
      end

      // Saturation: one entry held against back-pressure for 20 cycles
      drive(1, 0, 0, 0, 0, 0); tick();
      drive(0, 0, 1, PA, IA, 0); tick();
      for (int i = 0; i < 20; i++) begin
         drive(0, 0, 0, 0, 0, 0); tick();
      end
      drive(0, 0, 0, 0, 0, 0);
      check("sat_stall_cnt", 64'(stall_cnt), 64'(15));
      check("sat_head_pc", 64'(pc_incr_out), 64'(PA));
      tick();

      // Reset in FULL together with a push and a pop
      drive(0, 0, 1, PB, IB, 0); tick();
      drive(0, 0, 0, 0, 0, 0);
      check("full_in_ready", 64'(in_ready), 64'(0));
      tick();
      drive(1, 0, 1, PC, IC, 1);
      check("midrst_in_ready", 64'(in_ready), 64'(0));
      tick();
      drive(0, 0, 0, 0, 0, 0);
      check("midrst_out_valid", 64'(out_valid), 64'(0));
      check("midrst_pc", 64'(pc_incr_out), 64'(0));
      check("midrst_instr", 64'(instr_out), 64'(NOP));
      check("midrst_stall_cnt", 64'(stall_cnt), 64'(0));
      check("midrst_in_ready", 64'(in_ready), 64'(1));
      tick();

      // Randomized run against the queue model
      m_q.delete(); m_cnt = 0;
      drive(1, 0, 0, 0, 0, 0); tick();
      for (int i = 0; i < 3000; i++) begin
         drive(($urandom_range(0, 99) < 2), ($urandom_range(0, 15) == 0),
               ($urandom_range(0, 9) < 7), $urandom, $urandom,
               ($urandom_range(0, 9) < 5));
         check_model("rnd");
         tick();
      end

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule
